// File: rtl/gs_fetch_unit.sv
// gs_fetch_unit: instruction fetch with in-order response queue and redirect drain
module gs_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  typedef enum logic {RUN, DRAIN} state_t;
  state_t state, state_nx;
  logic [31:0] fetch_pc;
  logic [31:0] pc_q [DEPTH];
  logic [31:0] data_q [DEPTH];
  logic [DEPTH-1:0] filled;
  logic [AW-1:0] alloc_ptr, fill_ptr, rd_ptr;
  logic [CW-1:0] used, pend, drop_cnt, drop_nx, owed;
  logic issue, fill, pop;
  logic unused_pc_bits;
  assign unused_pc_bits = ^redirect_pc[1:0];
  assign out_valid = filled[rd_ptr] && !redirect_valid;
  assign pop = out_valid && out_ready;
  // a slot freed by this cycle's pop may be refilled at once, sustaining one instruction per cycle
  assign imem_req_valid = rst && state == RUN && (used < FULL || pop) && !redirect_valid;
  assign imem_req_addr = fetch_pc;
  assign issue = imem_req_valid && imem_req_ready;
  assign fill = state == RUN && imem_rsp_valid && pend != '0 && !redirect_valid;
  assign instr_o = out_valid ? data_q[rd_ptr] : 32'h0000_0013;
  assign pc_o = out_valid ? pc_q[rd_ptr] : 32'h0;
  assign owed = drop_cnt + pend;
  always_comb begin
    state_nx = state;
    drop_nx = drop_cnt;
    if (redirect_valid) begin
      drop_nx = owed - CW'(imem_rsp_valid && owed != '0);
      state_nx = drop_nx != '0 ? DRAIN : RUN;
    end else if (state == DRAIN) begin
      drop_nx = drop_cnt - CW'(imem_rsp_valid && drop_cnt != '0);
      state_nx = drop_nx != '0 ? DRAIN : RUN;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= RUN;
      fetch_pc <= RESET_PC;
      alloc_ptr <= '0;
      fill_ptr <= '0;
      rd_ptr <= '0;
      used <= '0;
      pend <= '0;
      drop_cnt <= '0;
      filled <= '0;
    end else begin
      state <= state_nx;
      drop_cnt <= drop_nx;
      if (redirect_valid) begin
        fetch_pc <= {redirect_pc[31:2], 2'b00};
        alloc_ptr <= '0;
        fill_ptr <= '0;
        rd_ptr <= '0;
        used <= '0;
        pend <= '0;
        filled <= '0;
      end else begin
        if (issue) fetch_pc <= fetch_pc + 32'd4;
        if (issue) alloc_ptr <= alloc_ptr + AW'(1);
        if (fill) fill_ptr <= fill_ptr + AW'(1);
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        used <= used + CW'(issue) - CW'(pop);
        pend <= pend + CW'(issue) - CW'(fill);
        if (pop) filled[rd_ptr] <= 1'b0;
        if (issue) filled[alloc_ptr] <= 1'b0;
        if (fill) filled[fill_ptr] <= 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (issue) pc_q[alloc_ptr] <= fetch_pc;
    if (fill) data_q[fill_ptr] <= imem_rsp_data;
  end
endmodule

// File: tb/tb_gs_fetch_unit.sv
// tb_gs_fetch_unit: random fetch traffic against a memory model and an ordered-stream reference
module tb_gs_fetch_unit;
  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam int DEPTH = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 1'b0, rst = 1'b0;
  logic imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic out_valid, out_ready = 1'b0;
  logic [31:0] instr_o, pc_o;
  gs_fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .instr_o(instr_o), .pc_o(pc_o)
  );
  always #5 clk = ~clk;
  int tests = 0, fails = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // memory contents: a bijection of the address so every word identifies its PC
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5a3c_96e1;
  endfunction
  logic [31:0] mq_addr[$];
  int mq_due[$];
  int cyc = 0, last_due = 0;
  int lat_lo = 1, lat_hi = 1, pr_ready = 100, pr_oready = 100, pr_redir = 0;
  bit force_redir = 0, redir_on_rsp = 0, spurious = 0, stream_on = 0, simul_hit = 0;
  logic [31:0] force_target = '0;
  logic [31:0] exp_req, exp_out, prev_pc, prev_instr;
  int live, idle, stale, first_acc, acc_cnt = 0;
  bit prev_hold, expect_issue;
  task automatic model_reset();
    mq_addr.delete();
    mq_due.delete();
    last_due = cyc;
    exp_req = RPC;
    exp_out = RPC;
    live = 0;
    idle = 0;
    stale = 0;
    first_acc = -1;
    prev_hold = 0;
    expect_issue = 0;
  endtask
  task automatic do_reset(input int n);
    rst = 1'b0;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b0;
    out_ready = 1'b0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_instr", instr_o, NOP);
    check("rst_pc", pc_o, 0);
    check("rst_req_valid", 32'(imem_req_valid), 0);
    model_reset();
    rst = 1'b1;
  endtask
  task automatic step();
    int stale_start, due;
    bit rsp;
    @(negedge clk);
    cyc++;
    rsp = mq_addr.size() > 0 && mq_due[0] <= cyc;
    imem_rsp_valid = rsp || spurious;
    imem_rsp_data = $urandom;
    if (rsp) begin
      imem_rsp_data = word_at(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    spurious = 0;
    imem_req_ready = $urandom_range(99) < pr_ready;
    out_ready = $urandom_range(99) < pr_oready;
    redirect_valid = (force_redir && (!redir_on_rsp || rsp)) || $urandom_range(99) < pr_redir;
    redirect_pc = $urandom;
    if (force_redir && redirect_valid) begin
      redirect_pc = force_target;
      force_redir = 0;
      if (redir_on_rsp) simul_hit = 1;
    end
    stale_start = stale;
    if (rsp && stale > 0) stale--;
    #1;
    if (prev_hold && !redirect_valid) begin
      check("hold_valid", 32'(out_valid), 1);
      check("hold_pc", pc_o, prev_pc);
      check("hold_instr", instr_o, prev_instr);
    end
    if (redirect_valid) begin
      check("redir_req", 32'(imem_req_valid), 0);
      check("redir_out", 32'(out_valid), 0);
    end
    if (stale_start > 0) check("drain_no_req", 32'(imem_req_valid), 0);
    if (expect_issue && !redirect_valid) check("resume_req", 32'(imem_req_valid), 1);
    if (stream_on && first_acc >= 0 && cyc >= first_acc + 2) check("stream_valid", 32'(out_valid), 1);
    if (out_valid) begin
      check("pc", pc_o, exp_out);
      check("instr", instr_o, word_at(exp_out));
    end else begin
      check("idle_instr", instr_o, NOP);
      check("idle_pc", pc_o, 0);
    end
    if (imem_req_valid && imem_req_ready) begin
      check("req_addr", imem_req_addr, exp_req);
      due = cyc + $urandom_range(lat_hi, lat_lo);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mq_addr.push_back(imem_req_addr);
      mq_due.push_back(due);
      exp_req += 32'd4;
      acc_cnt++;
      live++;
      if (first_acc < 0) first_acc = cyc;
    end
    if (out_valid && out_ready) begin
      exp_out += 32'd4;
      live--;
    end
    idle = out_valid ? 0 : idle + 1;
    check("live_bound", 32'(live <= DEPTH), 1);
    check("progress", 32'(idle < 40), 1);
    prev_hold = out_valid && !out_ready;
    prev_pc = pc_o;
    prev_instr = instr_o;
    expect_issue = stale_start > 0 && stale == 0;
    if (redirect_valid) begin
      exp_req = {redirect_pc[31:2], 2'b00};
      exp_out = exp_req;
      live = 0;
      prev_hold = 0;
      stale = mq_addr.size();
      expect_issue = stale == 0;
    end
  endtask
  initial begin
    int a0;
    do_reset(2);
    spurious = 1;
    pr_ready = 0;
    step();
    repeat (3) step();
    pr_ready = 100;
    do_reset(1);
    stream_on = 1;
    repeat (14) step();
    stream_on = 0;
    do_reset(1);
    pr_oready = 0;
    a0 = acc_cnt;
    repeat (5) step();
    check("bp_accepts", 32'(acc_cnt - a0), DEPTH);
    check("bp_head_pc", pc_o, RPC);
    pr_oready = 100;
    repeat (8) step();
    lat_lo = 3;
    lat_hi = 3;
    repeat (6) step();
    force_target = 32'h0000_2002;
    force_redir = 1;
    repeat (14) step();
    lat_lo = 2;
    lat_hi = 2;
    redir_on_rsp = 1;
    force_target = 32'h0000_3000;
    force_redir = 1;
    repeat (15) step();
    redir_on_rsp = 0;
    check("simul_hit", 32'(simul_hit), 1);
    lat_lo = 1;
    lat_hi = 1;
    force_target = 32'hFFFF_FFF8;
    force_redir = 1;
    repeat (12) step();
    pr_oready = 0;
    repeat (6) step();
    do_reset(1);
    pr_oready = 100;
    repeat (6) step();
    lat_lo = 1;
    lat_hi = 4;
    pr_ready = 70;
    pr_oready = 60;
    pr_redir = 5;
    for (int r = 0; r < 4; r++) begin
      repeat (800) step();
      do_reset(1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
